// File: rtl/mdu_hilo_if.sv
// rtl/mdu_hilo_if.sv - start/busy/done handshake, operands and HI/LO access for mdu_hilo
interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, din1, din2, wr_hi, wr_lo, wr_data,
        input  busy, done, dz, hi, lo
    );

    modport slave (
        input  start, op, din1, din2, wr_hi, wr_lo, wr_data,
        output busy, done, dz, hi, lo
    );
endinterface

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative shift-add multiplier / restoring divider owning HI/LO
// The divider is only built when MDU_DIV_EN is defined; otherwise op 11 completes as a no-op.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    mdu_hilo_if.slave   bus
);
    localparam int            W        = WIDTH;
    localparam logic [1:0]    OP_MULTU = 2'b01;
    localparam logic [1:0]    OP_MADD  = 2'b10;
    localparam logic [1:0]    OP_DIV   = 2'b11;
    localparam logic [5:0]    LAST     = 6'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t         r_state;
    logic [1:0]     r_op;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_opnd;
    logic           r_s1;
    logic           r_s2;
    logic [5:0]     r_cnt;
    logic           r_busy;
    logic           r_done;
    logic           r_dz;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;

    logic           w_signed;
    logic [W-1:0]   w_mag1;
    logic [W-1:0]   w_mag2;
    logic           w_neg;
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_prod;

    assign w_signed  = (bus.op != OP_MULTU);
    assign w_mag1    = (w_signed && bus.din1[W-1]) ? -bus.din1 : bus.din1;
    assign w_mag2    = (w_signed && bus.din2[W-1]) ? -bus.din2 : bus.din2;
    assign w_neg     = r_s1 ^ r_s2;

    // Upper half accumulates the multiplicand; the multiplier drains out of the low half.
    assign w_mul_sum = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_opnd : {W{1'b0}})};
    assign w_prod    = w_neg ? -r_acc : r_acc;

`ifdef MDU_DIV_EN
    logic [W:0]   w_rem_sh;
    logic [W:0]   w_diff;
    logic [W-1:0] w_quot_s;
    logic [W-1:0] w_rem_s;

    assign w_rem_sh = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_opnd};
    assign w_quot_s = r_dz ? {W{1'b1}} : (w_neg ? -r_acc[W-1:0] : r_acc[W-1:0]);
    // With a zero divisor every trial succeeds and the remainder ends as |din1|, so the
    // sign fix-up below restores the original dividend in HI.
    assign w_rem_s  = r_s1 ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_cnt   <= 6'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.wr_hi) r_hi <= bus.wr_data;
                    if (bus.wr_lo) r_lo <= bus.wr_data;
                    if (bus.start) begin
                        r_op  <= bus.op;
                        r_s1  <= w_signed & bus.din1[W-1];
                        r_s2  <= w_signed & bus.din2[W-1];
                        r_cnt <= 6'd0;
                        r_dz  <= 1'b0;
`ifdef MDU_DIV_EN
                        if (bus.op == OP_DIV) begin
                            r_dz   <= (bus.din2 == {W{1'b0}});
                            r_opnd <= w_mag2;
                            r_acc  <= {{W{1'b0}}, w_mag1};
                        end else begin
                            r_opnd <= w_mag1;
                            r_acc  <= {{W{1'b0}}, w_mag2};
                        end
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
`else
                        r_opnd <= w_mag1;
                        r_acc  <= {{W{1'b0}}, w_mag2};
                        if (bus.op == OP_DIV) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
`endif
                    end
                end
                S_RUN: begin
`ifdef MDU_DIV_EN
                    if (r_op == OP_DIV) begin
                        if (!w_diff[W])
                            r_acc <= {w_diff[W-1:0], r_acc[W-2:0], 1'b1};
                        else
                            r_acc <= {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[W-1:1]};
                    end
`else
                    r_acc <= {w_mul_sum, r_acc[W-1:1]};
`endif
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == LAST) r_state <= S_FIX;
                end
                S_FIX: begin
                    case (r_op)
                        OP_MADD: {r_hi, r_lo} <= {r_hi, r_lo} + w_prod;
`ifdef MDU_DIV_EN
                        OP_DIV: begin
                            r_hi <= w_rem_s;
                            r_lo <= w_quot_s;
                        end
`endif
                        default: {r_hi, r_lo} <= w_prod;
                    endcase
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dz   = r_dz;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - directed vector bench for mdu_hilo; expectations follow MDU_DIV_EN
module tb_mdu_hilo;
    localparam int W = 32;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_hilo_if #(.WIDTH(W)) bus_if ();
    mdu_hilo #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        bus_if.wr_hi = 1'b1; bus_if.wr_data = h;
        @(negedge clk);
        bus_if.wr_hi = 1'b0; bus_if.wr_lo = 1'b1; bus_if.wr_data = l;
        @(negedge clk);
        bus_if.wr_lo = 1'b0;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus_if.start = 1'b1; bus_if.op = op; bus_if.din1 = a; bus_if.din2 = b;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.din1  = 32'h5A5A5A5A;
        bus_if.din2  = 32'hA5A5A5A5;
        bus_if.op    = ~op;
    endtask

    // Entered at the negedge following E0; lat counts further edges until done is seen.
    task automatic wait_done(output int lat, output int bn);
        lat = -1;
        bn  = 0;
        for (int k = 0; k < 100; k++) begin
            if (bus_if.done) begin
                lat = k;
                break;
            end
            if (bus_if.busy) bn++;
            @(negedge clk);
        end
    endtask

    int lat, bn, seen;
    logic nodiv;
    logic [31:0] eh, el;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'h0,  32'h0,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,  32'h0,        32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h0,  32'h0,        32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{2'b00, 32'hFFFFFFFF, 32'd1,        32'h0,  32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{2'b01, 32'h12345678, 32'h10,       32'h0,  32'h0,        32'h00000001, 32'h23456780, 1'b0};
        vecs[5]  = '{2'b00, 32'd0,        32'd5,        32'h11, 32'h22,       32'h0,        32'h0,        1'b0};
        vecs[6]  = '{2'b10, 32'd1,        32'd1,        32'h0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        vecs[7]  = '{2'b10, 32'hFFFFFFFE, 32'd3,        32'h0,  32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'h33, 32'h44,       32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[9]  = '{2'b11, 32'd5,        32'd0,        32'h55, 32'h66,       32'h00000005, 32'hFFFFFFFF, 1'b1};
        vecs[10] = '{2'b11, 32'd100,      32'hFFFFFFF9, 32'h77, 32'h88,       32'h00000002, 32'hFFFFFFF2, 1'b0};
        vecs[11] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h99, 32'hAA,       32'h00000000, 32'h80000000, 1'b0};
        vecs[12] = '{2'b11, 32'hFFFFFFFB, 32'd0,        32'hBB, 32'hCC,       32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};

        bus_if.start = 1'b0; bus_if.op = 2'b00; bus_if.din1 = '0; bus_if.din2 = '0;
        bus_if.wr_hi = 1'b0; bus_if.wr_lo = 1'b0; bus_if.wr_data = '0;

        #12;
        chk("reset busy", 64'(bus_if.busy), 64'd0);
        chk("reset done", 64'(bus_if.done), 64'd0);
        chk("reset dz",   64'(bus_if.dz),   64'd0);
        chk("reset hi",   64'(bus_if.hi),   64'd0);
        chk("reset lo",   64'(bus_if.lo),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            write_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
            chk($sformatf("v%0d preload", i), {bus_if.hi, bus_if.lo}, {vecs[i].pre_hi, vecs[i].pre_lo});
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, bn);
            nodiv = (vecs[i].op == 2'b11) && !DIV_EN;
            eh = nodiv ? vecs[i].pre_hi : vecs[i].exp_hi;
            el = nodiv ? vecs[i].pre_lo : vecs[i].exp_lo;
            chk($sformatf("v%0d latency", i), 64'(lat), nodiv ? 64'd0 : 64'd33);
            chk($sformatf("v%0d busy", i),    64'(bn),  nodiv ? 64'd0 : 64'd33);
            chk($sformatf("v%0d hi", i),      64'(bus_if.hi), 64'(eh));
            chk($sformatf("v%0d lo", i),      64'(bus_if.lo), 64'(el));
            chk($sformatf("v%0d dz", i),      64'(bus_if.dz), nodiv ? 64'd0 : 64'(vecs[i].exp_dz));
            @(negedge clk);
            chk($sformatf("v%0d done pulse", i), 64'(bus_if.done), 64'd0);
        end

        // mtlo in the same cycle as a MADD start: accumulation starts from the written value
        write_hilo(32'h0, 32'hAA);
        bus_if.wr_lo = 1'b1; bus_if.wr_data = 32'h10;
        start_op(2'b10, 32'd2, 32'd3);
        bus_if.wr_lo = 1'b0;
        wait_done(lat, bn);
        chk("madd same-cycle", {bus_if.hi, bus_if.lo}, 64'h0000_0000_0000_0016);
        @(negedge clk);

        bus_if.wr_hi = 1'b1; bus_if.wr_lo = 1'b1; bus_if.wr_data = 32'hCAFEF00D;
        @(negedge clk);
        bus_if.wr_hi = 1'b0; bus_if.wr_lo = 1'b0;
        chk("dual write", {bus_if.hi, bus_if.lo}, 64'hCAFEF00D_CAFEF00D);

        // Start and mtlo during RUN are ignored
        start_op(2'b01, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = 2'b00; bus_if.din1 = 32'd100; bus_if.din2 = 32'd100;
        bus_if.wr_lo = 1'b1; bus_if.wr_data = 32'hDEAD;
        @(negedge clk);
        bus_if.start = 1'b0; bus_if.wr_lo = 1'b0;
        wait_done(lat, bn);
        chk("busy-start latency", 64'(lat), 64'd23);
        chk("busy-start result", {bus_if.hi, bus_if.lo}, 64'd42);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus_if.done || bus_if.busy) seen++;
        end
        chk("busy-start no second op", 64'(seen), 64'd0);

        // Back-to-back: start presented during the done cycle
        start_op(2'b01, 32'd2, 32'd3);
        wait_done(lat, bn);
        chk("b2b first", {bus_if.hi, bus_if.lo}, 64'd6);
        start_op(2'b01, 32'd5, 32'd5);
        wait_done(lat, bn);
        chk("b2b latency", 64'(lat), 64'd33);
        chk("b2b second", {bus_if.hi, bus_if.lo}, 64'd25);
        @(negedge clk);

        // Asynchronous reset in the middle of an operation
        write_hilo(32'h1234, 32'h5678);
        start_op(2'b00, 32'd3, 32'd4);
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst-mid busy", 64'(bus_if.busy), 64'd0);
        chk("rst-mid hilo", {bus_if.hi, bus_if.lo}, 64'd0);
        chk("rst-mid done", 64'(bus_if.done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus_if.done) seen++;
        end
        chk("rst-mid no done", 64'(seen), 64'd0);
        start_op(2'b00, 32'd3, 32'hFFFFFFFC);
        wait_done(lat, bn);
        chk("post-rst latency", 64'(lat), 64'd33);
        chk("post-rst result", {bus_if.hi, bus_if.lo}, 64'hFFFFFFFF_FFFFFFF4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
